dcache_axi_master: RTL and testbench
====================================

// Module: dcache_axi_master
// PURPOSE: AXI4 master-1 bridge directly downstream of the L1 D$. It turns one D$ request into an
//   AXI read burst (line refill) or a single-beat AXI write (write-through), and returns
//   per-beat refill data and a busy indication. It sits between the D$ and the AXI interconnect.
// PARAMETERS: BURST_LEN  4  beats per line refill (ARLEN = BURST_LEN-1); 32-bit beats, 128-bit line
// PORTS:
//   clk_i          in   1   clock
//   rst_i          in   1   asynchronous, active-high reset
//   D_req_i        in   1   D$ request strobe, one cycle; sampled only in IDLE
//   D_write_i      in   4   byte strobes; 4'b0000 = line read, otherwise word write
//   D_addr_i       in   32  request address (line-aligned for reads)
//   D_in_i         in   32  write data
//   D_wait_o       out  1   busy: high from the cycle after acceptance until the transaction ends
//   D_out_valid_o  out  1   refill beat valid (one cycle per beat)
//   D_out_o        out  32  refill beat data, ascending word order (word 0 first)
//   araddr_o       out  32  AR address
//   arlen_o        out  8   AR burst length, constant BURST_LEN-1
//   arvalid_o      out  1   AR valid
//   arready_i      in   1   AR ready
//   rdata_i        in   32  R data
//   rlast_i        in   1   R last beat
//   rvalid_i       in   1   R valid
//   rready_o       out  1   R ready
//   awaddr_o       out  32  AW address (single beat; AWLEN=0)
//   awvalid_o      out  1   AW valid
//   awready_i      in   1   AW ready
//   wdata_o        out  32  W data
//   wstrb_o        out  4   W byte strobes
//   wvalid_o       out  1   W valid
//   wready_i       in   1   W ready
//   bvalid_i       in   1   B valid
//   bready_o       out  1   B ready
// BEHAVIOUR:
// - The top-level wrapper ties SIZE=3'b010, BURST=INCR, AWLEN=0 and WLAST=1. IDs and RESP are
//   handled in the interconnect; they are not ports of this block.
// - Reset (async, any time): state=IDLE, beat_cnt=0, aw_done=w_done=0. All valid/ready outputs,
//   D_wait_o and D_out_valid_o are 0. Address/data outputs are 0. A transaction in flight is
//   abandoned without completing.
// - FSM IDLE -> AR -> R -> IDLE (read), IDLE -> AW_W -> B -> IDLE (write).
// - IDLE: on D_req_i, latch addr, write and data into registers and go to AR if D_write_i==0,
//   else AW_W. D_req_i is ignored in any other state.
// - D_wait_o is registered and equals (state != IDLE). It is therefore low in the cycle
//   D_req_i is accepted.
// - AR: arvalid_o=1, araddr_o = {addr[31:4], 4'h0}. Hold until arready_i, then go to R.
//   arvalid must not drop before the handshake.
// - R: rready_o=1. On each rvalid_i & rready_o:
//   - D_out_valid_o=1 and D_out_o=rdata_i in the same cycle (combinational, zero added latency).
//   - beat_cnt increments (log2(BURST_LEN) bits, wraps to 0).
//   - If rlast_i: go to IDLE, so D_wait_o falls the next cycle.
// - An rvalid_i gap holds the state with D_out_valid_o=0. A missing or early rlast is an
//   interconnect error; the simulation assertion fires when beat_cnt != BURST_LEN-1 at rlast.
// - AW_W: awvalid_o and wvalid_o rise together.
//   - awaddr_o = addr, wdata_o = data, wstrb_o = write.
//   - Each valid drops after its own handshake (aw_done / w_done flags). The two channels may
//     complete in either order or in the same cycle.
//   - When both handshakes are done (including same-cycle completion), go to B.
// - B: bready_o=1. On bvalid_i go to IDLE. D_out_valid_o is never asserted for writes.
// - Minimum read = 1 (AR) + BURST_LEN (R) cycles busy. Minimum write = 1 (AW_W) + 1 (B) cycles busy.
// TESTING:
// - Read 0x0000_1230, arready at once, R beats 0xA0..0xA3 back-to-back -> araddr 0x1230, arlen 3,
//   4 D_out_valid pulses in order, D_wait high for 5 cycles.
// - Read with arready delayed 3 cycles and a 2-cycle rvalid gap after beat 1 -> arvalid held
//   steady, only 4 valid pulses, data order preserved.
// - Write 0x0000_2004, data 0xDEADBEEF, strb 4'b0011; wready before awready, bvalid 2 cycles
//   later -> wvalid drops first, awaddr 0x2004, wstrb 0x3, no D_out_valid, D_wait falls after B.
// - Write with awready and wready in the same cycle -> AW_W lasts exactly 1 cycle, then B.
// - D_req_i pulsed while in R -> ignored, no second AR.
// - rst_i asserted mid-burst after beat 2 -> all outputs 0 immediately; the next read starts cleanly.

Source files
------------

// File: rtl/dcache_axi_master_if.sv
// AXI4 master-side bus of the D$ bridge: AR/R for line refills, AW/W/B for write-through.
// Member names carry the direction suffix as seen from the bridge.
interface dcache_axi_master_if;
    logic [31:0] araddr_o;
    logic [7:0]  arlen_o;
    logic        arvalid_o;
    logic        arready_i;
    logic [31:0] rdata_i;
    logic        rlast_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [31:0] awaddr_o;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] wdata_o;
    logic [3:0]  wstrb_o;
    logic        wvalid_o;
    logic        wready_i;
    logic        bvalid_i;
    logic        bready_o;

    modport master (
        output araddr_o, arlen_o, arvalid_o, rready_o,
        output awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        input  arready_i, rdata_i, rlast_i, rvalid_i, awready_i, wready_i, bvalid_i
    );

    modport slave (
        input  araddr_o, arlen_o, arvalid_o, rready_o,
        input  awaddr_o, awvalid_o, wdata_o, wstrb_o, wvalid_o, bready_o,
        output arready_i, rdata_i, rlast_i, rvalid_i, awready_i, wready_i, bvalid_i
    );
endinterface

// File: rtl/dcache_axi_master.sv
// D$-to-AXI4 bridge: one request becomes either a BURST_LEN-beat line refill or a
// single-beat write-through; refill beats are forwarded to the D$ with no added latency.
module dcache_axi_master #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                D_req_i,
    input  logic [3:0]          D_write_i,
    input  logic [31:0]         D_addr_i,
    input  logic [31:0]         D_in_i,
    output logic                D_wait_o,
    output logic                D_out_valid_o,
    output logic [31:0]         D_out_o,
    dcache_axi_master_if.master axi
);
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [2:0] {IDLE, AR, R, AW_W, B} state_e;

    state_e        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [3:0]    strb_q, strb_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d;
    logic          aw_done_q, aw_done_d;
    logic          w_done_q, w_done_d;
    logic          wait_q;
    logic          r_fire, aw_fire, w_fire;

    assign axi.arlen_o  = 8'(BURST_LEN - 1);
    assign axi.araddr_o = {addr_q[31:4], 4'h0};
    assign axi.awaddr_o = addr_q;
    assign axi.wdata_o  = data_q;
    assign axi.wstrb_o  = strb_q;
    assign D_wait_o     = wait_q;

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        strb_d        = strb_q;
        beat_cnt_d    = beat_cnt_q;
        aw_done_d     = aw_done_q;
        w_done_d      = w_done_q;
        axi.arvalid_o = (state_q == AR);
        axi.rready_o  = (state_q == R);
        axi.awvalid_o = (state_q == AW_W) && !aw_done_q;
        axi.wvalid_o  = (state_q == AW_W) && !w_done_q;
        axi.bready_o  = (state_q == B);
        r_fire        = (state_q == R) && axi.rvalid_i;
        aw_fire       = (state_q == AW_W) && !aw_done_q && axi.awready_i;
        w_fire        = (state_q == AW_W) && !w_done_q && axi.wready_i;
        D_out_valid_o = r_fire;
        D_out_o       = r_fire ? axi.rdata_i : '0;

        case (state_q)
            IDLE: begin
                if (D_req_i) begin
                    addr_d     = D_addr_i;
                    data_d     = D_in_i;
                    strb_d     = D_write_i;
                    beat_cnt_d = '0;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                    state_d    = (D_write_i == 4'b0000) ? AR : AW_W;
                end
            end
            AR: begin
                if (axi.arready_i) state_d = R;
            end
            R: begin
                if (r_fire) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (axi.rlast_i) state_d = IDLE;
                end
            end
            AW_W: begin
                // Each channel retires independently; same-cycle completion of the
                // second one is folded in through the _d values.
                aw_done_d = aw_done_q | aw_fire;
                w_done_d  = w_done_q | w_fire;
                if (aw_done_d && w_done_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = B;
                end
            end
            B: begin
                if (axi.bvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            strb_q     <= '0;
            beat_cnt_q <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            wait_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            strb_q     <= strb_d;
            beat_cnt_q <= beat_cnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            wait_q     <= (state_d != IDLE);
        end
    end

    // A missing or premature rlast means the interconnect broke the burst length.
    always_ff @(posedge clk_i) begin
        if (!rst_i && r_fire && axi.rlast_i)
            assert (beat_cnt_q == CW'(BURST_LEN - 1));
    end
endmodule

// File: tb/tb_dcache_axi_master.sv
// Directed bench for dcache_axi_master: inputs change on the falling edge, outputs are
// checked 1ns later against hand-computed values.
module tb_dcache_axi_master;
    logic        clk = 1'b0;
    logic        rst;
    logic        d_req;
    logic [3:0]  d_write;
    logic [31:0] d_addr;
    logic [31:0] d_in;
    logic        d_wait;
    logic        d_out_valid;
    logic [31:0] d_out;
    int          pass_cnt  = 0;
    int          total_cnt = 0;
    int          pulses;

    dcache_axi_master_if bus ();

    dcache_axi_master #(.BURST_LEN(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .D_req_i       (d_req),
        .D_write_i     (d_write),
        .D_addr_i      (d_addr),
        .D_in_i        (d_in),
        .D_wait_o      (d_wait),
        .D_out_valid_o (d_out_valid),
        .D_out_o       (d_out),
        .axi           (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".wait"},    32'(d_wait), 32'd0);
        chk({tag, ".arvalid"}, 32'(bus.arvalid_o), 32'd0);
        chk({tag, ".rready"},  32'(bus.rready_o), 32'd0);
        chk({tag, ".awvalid"}, 32'(bus.awvalid_o), 32'd0);
        chk({tag, ".wvalid"},  32'(bus.wvalid_o), 32'd0);
        chk({tag, ".bready"},  32'(bus.bready_o), 32'd0);
        chk({tag, ".dvalid"},  32'(d_out_valid), 32'd0);
    endtask

    task automatic beat(input string tag, input logic [31:0] data, input logic last);
        bus.rvalid_i = 1'b1;
        bus.rdata_i  = data;
        bus.rlast_i  = last;
        settle();
        chk({tag, ".rready"}, 32'(bus.rready_o), 32'd1);
        chk({tag, ".dvalid"}, 32'(d_out_valid), 32'd1);
        chk({tag, ".dout"},   d_out, data);
        chk({tag, ".wait"},   32'(d_wait), 32'd1);
        if (d_out_valid) pulses++;
    endtask

    initial begin
        rst = 1'b1; d_req = 1'b0; d_write = 4'h0; d_addr = '0; d_in = '0;
        bus.arready_i = 1'b0; bus.rdata_i = '0; bus.rlast_i = 1'b0; bus.rvalid_i = 1'b0;
        bus.awready_i = 1'b0; bus.wready_i = 1'b0; bus.bvalid_i = 1'b0;

        // Reset state
        step(); settle();
        chk_idle("rst");
        chk("rst.araddr", bus.araddr_o, 32'h0);
        chk("rst.awaddr", bus.awaddr_o, 32'h0);
        chk("rst.wdata",  bus.wdata_o, 32'h0);
        chk("rst.dout",   d_out, 32'h0);
        step(); rst = 1'b0;

        // Read 0x1230, arready at once, back-to-back beats
        step(); d_req = 1'b1; d_write = 4'h0; d_addr = 32'h0000_1230; settle();
        chk("rd1.accept_wait", 32'(d_wait), 32'd0);
        step(); d_req = 1'b0; bus.arready_i = 1'b1; settle();
        chk("rd1.arvalid", 32'(bus.arvalid_o), 32'd1);
        chk("rd1.araddr",  bus.araddr_o, 32'h0000_1230);
        chk("rd1.arlen",   32'(bus.arlen_o), 32'd3);
        chk("rd1.wait_ar", 32'(d_wait), 32'd1);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(); bus.arready_i = 1'b0;
            beat("rd1.beat", 32'hA0 + 32'(i), i == 3);
            chk("rd1.arvalid_r", 32'(bus.arvalid_o), 32'd0);
        end
        step(); bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0; settle();
        chk_idle("rd1.end");
        chk("rd1.pulses", 32'(pulses), 32'd4);

        // Read 0x4567 (line-aligned to 0x4560), arready after 3 cycles, rvalid gap,
        // and a stray D_req during R
        step(); d_req = 1'b1; d_addr = 32'h0000_4567; settle();
        for (int i = 0; i < 3; i++) begin
            step(); d_req = 1'b0; settle();
            chk("rd2.arvalid_hold", 32'(bus.arvalid_o), 32'd1);
            chk("rd2.araddr_hold",  bus.araddr_o, 32'h0000_4560);
        end
        step(); bus.arready_i = 1'b1; settle();
        chk("rd2.arvalid_hs", 32'(bus.arvalid_o), 32'd1);
        pulses = 0;
        step(); bus.arready_i = 1'b0; beat("rd2.b0", 32'hB0, 1'b0);
        step(); beat("rd2.b1", 32'hB1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(); bus.rvalid_i = 1'b0; bus.rdata_i = 32'hFFFF_FFFF;
            d_req = (i == 0); d_addr = 32'h0000_9990; settle();
            chk("rd2.gap_dvalid", 32'(d_out_valid), 32'd0);
            chk("rd2.gap_rready", 32'(bus.rready_o), 32'd1);
            chk("rd2.gap_wait",   32'(d_wait), 32'd1);
        end
        step(); d_req = 1'b0; beat("rd2.b2", 32'hB2, 1'b0);
        step(); beat("rd2.b3", 32'hB3, 1'b1);
        step(); bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0; settle();
        chk_idle("rd2.end");
        chk("rd2.pulses", 32'(pulses), 32'd4);
        step(); settle();
        chk("rd2.no_second_ar", 32'(bus.arvalid_o), 32'd0);
        chk("rd2.still_idle",   32'(d_wait), 32'd0);

        // Write 0x2004: wready before awready, bvalid two cycles into B
        step(); d_req = 1'b1; d_write = 4'b0011; d_addr = 32'h0000_2004; d_in = 32'hDEAD_BEEF; settle();
        chk("wr1.accept_wait", 32'(d_wait), 32'd0);
        step(); d_req = 1'b0; bus.wready_i = 1'b1; settle();
        chk("wr1.awvalid", 32'(bus.awvalid_o), 32'd1);
        chk("wr1.wvalid",  32'(bus.wvalid_o), 32'd1);
        chk("wr1.awaddr",  bus.awaddr_o, 32'h0000_2004);
        chk("wr1.wdata",   bus.wdata_o, 32'hDEAD_BEEF);
        chk("wr1.wstrb",   32'(bus.wstrb_o), 32'h3);
        chk("wr1.arvalid", 32'(bus.arvalid_o), 32'd0);
        step(); bus.wready_i = 1'b0; bus.awready_i = 1'b1; settle();
        chk("wr1.wvalid_drop", 32'(bus.wvalid_o), 32'd0);
        chk("wr1.awvalid_hold", 32'(bus.awvalid_o), 32'd1);
        chk("wr1.bready_early", 32'(bus.bready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(); bus.awready_i = 1'b0; bus.bvalid_i = (i == 2); settle();
            chk("wr1.bready",  32'(bus.bready_o), 32'd1);
            chk("wr1.awvalid_b", 32'(bus.awvalid_o), 32'd0);
            chk("wr1.wait_b",  32'(d_wait), 32'd1);
            chk("wr1.dvalid",  32'(d_out_valid), 32'd0);
        end
        step(); bus.bvalid_i = 1'b0; settle();
        chk_idle("wr1.end");

        // Write with awready and wready in the same cycle
        step(); d_req = 1'b1; d_write = 4'hF; d_addr = 32'h0000_3008; d_in = 32'h1234_5678; settle();
        step(); d_req = 1'b0; bus.awready_i = 1'b1; bus.wready_i = 1'b1; settle();
        chk("wr2.awvalid", 32'(bus.awvalid_o), 32'd1);
        chk("wr2.wvalid",  32'(bus.wvalid_o), 32'd1);
        chk("wr2.wstrb",   32'(bus.wstrb_o), 32'hF);
        step(); bus.awready_i = 1'b0; bus.wready_i = 1'b0; bus.bvalid_i = 1'b1; settle();
        chk("wr2.bready",  32'(bus.bready_o), 32'd1);
        chk("wr2.awvalid_b", 32'(bus.awvalid_o), 32'd0);
        chk("wr2.wvalid_b",  32'(bus.wvalid_o), 32'd0);
        step(); bus.bvalid_i = 1'b0; settle();
        chk_idle("wr2.end");

        // Reset after two refill beats, then a clean read
        step(); d_req = 1'b1; d_write = 4'h0; d_addr = 32'h0000_5670; settle();
        step(); d_req = 1'b0; bus.arready_i = 1'b1; settle();
        step(); bus.arready_i = 1'b0; beat("rs.b0", 32'hC0, 1'b0);
        step(); beat("rs.b1", 32'hC1, 1'b0);
        step(); bus.rdata_i = 32'hC2; rst = 1'b1; settle();
        chk_idle("rs.async");
        chk("rs.dout",   d_out, 32'h0);
        chk("rs.araddr", bus.araddr_o, 32'h0);
        step(); rst = 1'b0; bus.rvalid_i = 1'b0; settle();
        chk_idle("rs.after");
        step(); d_req = 1'b1; d_addr = 32'h0000_6780; settle();
        step(); d_req = 1'b0; bus.arready_i = 1'b1; settle();
        chk("rs2.araddr", bus.araddr_o, 32'h0000_6780);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(); bus.arready_i = 1'b0;
            beat("rs2.beat", 32'hD0 + 32'(i), i == 3);
        end
        step(); bus.rvalid_i = 1'b0; bus.rlast_i = 1'b0; settle();
        chk_idle("rs2.end");
        chk("rs2.pulses", 32'(pulses), 32'd4);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
